// File: rtl/bus_mem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_responder_if
// Description : Request/acknowledge bus bundle between an initiator and a
//               memory responder; signal names follow the responder's view.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_mem_responder_if #(
    parameter int BUS_WIDTH  = 32,
    parameter int CTRL_WIDTH = 8
);
    logic                  bus_req;
    logic [BUS_WIDTH-1:0]  bus_in;
    logic [CTRL_WIDTH-1:0] ctrl_in;
    logic                  bus_ack;
    logic [BUS_WIDTH-1:0]  bus_out;
    logic [CTRL_WIDTH-1:0] ctrl_out;

    modport master (
        output bus_req, bus_in, ctrl_in,
        input  bus_ack, bus_out, ctrl_out
    );

    modport slave (
        input  bus_req, bus_in, ctrl_in,
        output bus_ack, bus_out, ctrl_out
    );
endinterface
`default_nettype wire

// File: rtl/bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : bus_mem_responder
// Description : Bus responder serving single/burst reads and writes from an
//               internal word-addressed RAM after a fixed wait-state latency.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_mem_responder #(
    parameter int BUS_WIDTH   = 32,
    parameter int CTRL_WIDTH  = 8,
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    bus_mem_responder_if.slave    bus
);

    localparam logic [3:0] c_LAT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;
    localparam int         c_DEPTH    = 2 ** ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_LAT   = 2'd2,
        S_DATA  = 2'd3
    } state_t;

    state_t                 r_state;
    logic                   r_ack;
    logic                   r_wait;
    logic [BUS_WIDTH-1:0]   r_rdata;
    logic [ADDR_BITS-1:0]   r_addr;
    logic                   r_we;
    logic [2:0]             r_beats_left;
    logic [3:0]             r_wait_cnt;
    logic [BUS_WIDTH-1:0]   r_mem [c_DEPTH];

    logic                   w_req;
    logic [ADDR_BITS-1:0]   w_in_addr;
    logic [ADDR_BITS-1:0]   w_pf_addr;
    logic [BUS_WIDTH-1:0]   w_pf_data;
    logic                   w_last;
    logic                   w_mem_we;
    logic                   w_unused_ctrl;

    assign w_req         = bus.bus_req;
    assign w_in_addr     = bus.bus_in[ADDR_BITS-1:0];
    assign w_last        = (r_beats_left == 3'd0);
    assign w_mem_we      = (r_state == S_DATA) && w_req && r_we;
    assign w_unused_ctrl = &{1'b0, bus.ctrl_in};

    // Address of the word that must sit on bus_out during the next cycle, so
    // read data is loaded one edge ahead of the beat that presents it.
    always_comb begin
        w_pf_addr = r_addr;
        case (r_state)
            S_GRANT: w_pf_addr = w_in_addr;
            S_DATA:  w_pf_addr = r_addr + ADDR_BITS'(1);
            default: w_pf_addr = r_addr;
        endcase
    end

    assign w_pf_data = r_mem[w_pf_addr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_ack        <= 1'b0;
            r_wait       <= 1'b0;
            r_rdata      <= '0;
            r_addr       <= '0;
            r_we         <= 1'b0;
            r_beats_left <= 3'd0;
            r_wait_cnt   <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        r_state <= S_GRANT;
                        r_ack   <= 1'b1;
                        r_wait  <= 1'b1;
                    end
                end
                S_GRANT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                        r_wait  <= 1'b0;
                    end else begin
                        r_addr       <= w_in_addr;
                        r_we         <= bus.ctrl_in[0];
                        r_beats_left <= bus.ctrl_in[3:1];
                        if (WAIT_CYCLES > 0) begin
                            r_state    <= S_LAT;
                            r_wait_cnt <= c_LAT_LOAD;
                        end else begin
                            r_state <= S_DATA;
                            r_wait  <= 1'b0;
                            if (!bus.ctrl_in[0]) begin
                                r_rdata <= w_pf_data;
                            end
                        end
                    end
                end
                S_LAT: begin
                    if (!w_req) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                        r_wait  <= 1'b0;
                    end else if (r_wait_cnt == 4'd0) begin
                        r_state <= S_DATA;
                        r_wait  <= 1'b0;
                        if (!r_we) begin
                            r_rdata <= w_pf_data;
                        end
                    end else begin
                        r_wait_cnt <= r_wait_cnt - 4'd1;
                    end
                end
                S_DATA: begin
                    if (!w_req || w_last) begin
                        r_state <= S_IDLE;
                        r_ack   <= 1'b0;
                        r_wait  <= 1'b0;
                    end else begin
                        r_addr       <= r_addr + ADDR_BITS'(1);
                        r_beats_left <= r_beats_left - 3'd1;
                        if (!r_we) begin
                            r_rdata <= w_pf_data;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_ack   <= 1'b0;
                    r_wait  <= 1'b0;
                end
            endcase
        end
    end

    // RAM contents deliberately survive reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[r_addr] <= bus.bus_in;
        end
    end

    assign bus.bus_ack  = r_ack;
    assign bus.bus_out  = r_rdata;
    assign bus.ctrl_out = {{(CTRL_WIDTH-1){1'b0}}, r_wait};

endmodule
`default_nettype wire

// File: tb/tb_bus_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_mem_responder
// Description : Directed self-checking bench for bus_mem_responder, covering
//               WAIT_CYCLES=2 and WAIT_CYCLES=0 instances.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_mem_responder;

    logic clk = 1'b0;
    logic rst;
    int   checks   = 0;
    int   failures = 0;
    logic [31:0] d [8];
    logic [31:0] e [8];

    always #5 clk = ~clk;

    bus_mem_responder_if #(.BUS_WIDTH(32), .CTRL_WIDTH(8)) bi2 ();
    bus_mem_responder_if #(.BUS_WIDTH(32), .CTRL_WIDTH(8)) bi0 ();

    bus_mem_responder #(
        .BUS_WIDTH(32), .CTRL_WIDTH(8), .ADDR_BITS(10), .WAIT_CYCLES(2)
    ) dut2 (
        .clk   (clk),
        .reset (rst),
        .bus   (bi2)
    );

    bus_mem_responder #(
        .BUS_WIDTH(32), .CTRL_WIDTH(8), .ADDR_BITS(10), .WAIT_CYCLES(0)
    ) dut0 (
        .clk   (clk),
        .reset (rst),
        .bus   (bi0)
    );

    function automatic logic get_ack(bit sel);
        return sel ? bi0.bus_ack : bi2.bus_ack;
    endfunction

    function automatic logic get_wait(bit sel);
        return sel ? bi0.ctrl_out[0] : bi2.ctrl_out[0];
    endfunction

    function automatic logic [31:0] get_dout(bit sel);
        return sel ? bi0.bus_out : bi2.bus_out;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(bit sel, logic req, logic [31:0] din, logic [7:0] ctl);
        if (sel) begin
            bi0.bus_req = req; bi0.bus_in = din; bi0.ctrl_in = ctl;
        end else begin
            bi2.bus_req = req; bi2.bus_in = din; bi2.ctrl_in = ctl;
        end
    endtask

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_hs(string tag, bit sel, logic ack, logic wt);
        chk({tag, "_ack"},  32'(get_ack(sel)),  32'(ack));
        chk({tag, "_wait"}, 32'(get_wait(sel)), 32'(wt));
    endtask

    // abort_at == n means the burst runs to completion
    task automatic write_burst(bit sel, logic [31:0] addr, logic [7:0] ctl,
                               input logic [31:0] data [8], int n, int abort_at);
        int nw = sel ? 0 : 2;
        drive(sel, 1'b1, addr, ctl);
        chk_hs("wr_idle", sel, 1'b0, 1'b0);
        step();
        chk_hs("wr_grant", sel, 1'b1, 1'b1);
        step();
        repeat (nw) begin
            chk_hs("wr_lat", sel, 1'b1, 1'b1);
            step();
        end
        for (int i = 0; i < n; i++) begin
            if (i == abort_at) begin
                drive(sel, 1'b0, data[i], ctl);
                step();
                chk_hs("wr_abort", sel, 1'b0, 1'b0);
                return;
            end
            drive(sel, 1'b1, data[i], ctl);
            chk_hs($sformatf("wr_beat%0d", i), sel, 1'b1, 1'b0);
            step();
        end
        drive(sel, 1'b0, 32'h0, 8'h00);
        chk_hs("wr_done", sel, 1'b0, 1'b0);
    endtask

    task automatic read_burst(bit sel, logic [31:0] addr, logic [7:0] ctl,
                              input logic [31:0] exp [8], int n);
        int nw = sel ? 0 : 2;
        drive(sel, 1'b1, addr, ctl);
        chk_hs("rd_idle", sel, 1'b0, 1'b0);
        step();
        chk_hs("rd_grant", sel, 1'b1, 1'b1);
        step();
        drive(sel, 1'b1, 32'hDEAD_BEEF, ctl);
        repeat (nw) begin
            chk_hs("rd_lat", sel, 1'b1, 1'b1);
            step();
        end
        for (int i = 0; i < n; i++) begin
            chk_hs($sformatf("rd_beat%0d", i), sel, 1'b1, 1'b0);
            chk($sformatf("rd_data%0d", i), get_dout(sel), exp[i]);
            step();
        end
        drive(sel, 1'b0, 32'h0, 8'h00);
        chk_hs("rd_done", sel, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        drive(1'b1, 1'b0, 32'h0, 8'h00);
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack2",  32'(bi2.bus_ack), 32'h0);
        chk("rst_ctrl2", 32'(bi2.ctrl_out), 32'h0);
        chk("rst_dout2", bi2.bus_out, 32'h0);
        chk("rst_ack0",  32'(bi0.bus_ack), 32'h0);
        chk("rst_dout0", bi0.bus_out, 32'h0);
        rst = 1'b0;
        step();

        // Single-beat write then read at address 5
        d = '{32'h1234_5678, 0, 0, 0, 0, 0, 0, 0};
        write_burst(1'b0, 32'h5, 8'h01, d, 1, 1);
        e = '{32'h1234_5678, 0, 0, 0, 0, 0, 0, 0};
        read_burst(1'b0, 32'h5, 8'h00, e, 1);

        // Burst of 4 at 0x10
        d = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0};
        write_burst(1'b0, 32'h10, 8'h07, d, 4, 4);
        read_burst(1'b0, 32'h10, 8'h06, d, 4);

        // Wrap from 0x3FE through 0x000, then alias 0x1400 -> 0x000
        d = '{32'h1, 32'h2, 32'h3, 0, 0, 0, 0, 0};
        write_burst(1'b0, 32'h3FE, 8'h05, d, 3, 3);
        read_burst(1'b0, 32'h3FE, 8'h04, d, 3);
        e = '{32'h3, 0, 0, 0, 0, 0, 0, 0};
        read_burst(1'b0, 32'h1400, 8'hF0, e, 1);

        // Zero-latency instance, burst of 8
        d = '{32'hC0, 32'hC1, 32'hC2, 32'hC3, 32'hC4, 32'hC5, 32'hC6, 32'hC7};
        write_burst(1'b1, 32'h40, 8'h0F, d, 8, 8);
        read_burst(1'b1, 32'h40, 8'h0E, d, 8);

        // Abort a write burst after two beats
        d = '{32'h11, 32'h12, 32'h13, 32'h14, 0, 0, 0, 0};
        write_burst(1'b0, 32'h20, 8'h07, d, 4, 4);
        d = '{32'hB0, 32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5, 32'hB6, 32'hB7};
        write_burst(1'b0, 32'h20, 8'h0F, d, 8, 2);
        e = '{32'hB0, 32'hB1, 32'h13, 32'h14, 0, 0, 0, 0};
        read_burst(1'b0, 32'h20, 8'h06, e, 4);

        // Asynchronous reset in the middle of LAT
        drive(1'b0, 1'b1, 32'h10, 8'h06);
        step();
        step();
        chk_hs("pre_rst", 1'b0, 1'b1, 1'b1);
        chk("pre_rst_dout", bi2.bus_out, 32'h14);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_ack",  32'(bi2.bus_ack), 32'h0);
        chk("async_rst_wait", 32'(bi2.ctrl_out[0]), 32'h0);
        chk("async_rst_dout", bi2.bus_out, 32'h0);
        drive(1'b0, 1'b0, 32'h0, 8'h00);
        @(posedge clk);
        #1 rst = 1'b0;
        step();
        e = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 0, 0, 0, 0};
        read_burst(1'b0, 32'h10, 8'h06, e, 4);
        e = '{32'h1, 32'h2, 32'h3, 0, 0, 0, 0, 0};
        read_burst(1'b0, 32'h3FE, 8'h04, e, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/bus_mem_responder.md
Name: bus_mem_responder

Overview:
- Bus responder (slave) for the single-initiator request/acknowledge bus used by the display pipeline's pixel fetcher and other masters.
- Accepts an address and a control word, then serves single or burst reads and writes from an internal word-addressed RAM, with a programmable initial latency.
- Signals per-beat data validity to the initiator over a wait line on ctrl_out[0].
- Sits on the far side of the bus from any initiator: its outputs connect to the initiator's bus_ack/bus_in/ctrl_in, and its inputs connect to the initiator's bus_req/bus_out/ctrl_out.

Parameters:
- BUS_WIDTH, 32, width of the address/data buses.
- CTRL_WIDTH, 8, width of the control buses; must be >= 4.
- ADDR_BITS, 10, RAM depth is 2**ADDR_BITS words; upper address bits are ignored.
- WAIT_CYCLES, 2, wait-state cycles between address capture and first data beat; range 0..15.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- bus_req  in  1  initiator request; held high for the whole transaction.
- bus_in  in  BUS_WIDTH  address during GRANT; write data during write beats.
- ctrl_in  in  CTRL_WIDTH  [0] = 1 for write, 0 for read; [3:1] = burst length minus 1 (0 means 1 beat); upper bits ignored.
- bus_ack  out  1  transaction granted and in progress.
- bus_out  out  BUS_WIDTH  read data; valid only while bus_ack=1 and ctrl_out[0]=0 in a read.
- ctrl_out  out  CTRL_WIDTH  [0] = bus_wait (1 = data not yet valid); other bits are tied to 0.

Behaviour:
- All outputs are registered (Moore outputs).
- Reset (asynchronous, any state): state=IDLE; bus_ack=0; bus_wait=0; bus_out=0; beat and wait counters cleared. RAM contents are not reset and are retained.
- IDLE:
  - Outputs: ack=0, wait=0.
  - bus_req=1 sampled at an edge -> GRANT. From the next cycle, ack=1 and wait=1.
- GRANT (exactly 1 cycle):
  - At its closing edge, capture addr=bus_in[ADDR_BITS-1:0], we=ctrl_in[0], len=ctrl_in[3:1]+1.
  - Next state is LAT if WAIT_CYCLES>0, else DATA.
- LAT:
  - Lasts exactly WAIT_CYCLES cycles with wait=1, ack=1.
  - Then -> DATA.
- DATA:
  - len consecutive cycles with wait=0, ack=1, one beat per cycle; beat i uses address (addr+i) mod 2**ADDR_BITS, wrapping from top to 0.
  - Read beat: bus_out = RAM[addr+i] for that cycle. The RAM read must be prefetched so that the first beat has no bubble.
  - Write beat: RAM[addr+i] <= bus_in at the closing edge of that beat cycle. bus_out holds its last value.
  - After the last beat -> IDLE (ack=0, wait=0 on the next cycle).
- Timing summary:
  - ack stays high for exactly 1+WAIT_CYCLES+len cycles.
  - First beat occurs 2+WAIT_CYCLES cycles after the edge that sampled bus_req.
- Back-to-back transactions: IDLE always lasts at least 1 cycle. A bus_req still high in that IDLE cycle starts the next transaction, with GRANT following.
- Abort: bus_req=0 sampled in GRANT, LAT or DATA -> IDLE at the next edge with ack=0 and wait=0.
  - No write occurs at that edge or afterwards.
  - Writes completed in earlier beats persist.
- Read-after-write to the same address in the next transaction returns the written data.
- Unused ctrl_in bits and bus_in bits above ADDR_BITS are ignored; they produce no error.

Test Plan:
- Reset, then read of addr 5 with burst length 1 (ctrl_in=0x00), WAIT_CYCLES=2 -> ack rises 1 cycle after the req edge; wait=1 for 3 cycles; then 1 cycle with wait=0 and bus_out=RAM[5]; then ack=0.
- Write burst of 4 at addr 0x10 (ctrl_in=0x07) with data 0xA0..0xA3, then read burst of 4 at 0x10 -> read beats return 0xA0, 0xA1, 0xA2, 0xA3 on consecutive cycles with wait=0 throughout.
- Wrap-around: write burst of 3 at addr 0x3FE (ADDR_BITS=10) with 1, 2, 3 -> RAM[0x3FE]=1, RAM[0x3FF]=2, RAM[0x000]=3. Also drive address 0x1400 -> it aliases to 0x000.
- WAIT_CYCLES=0 build, read burst of 8 -> ack high for 9 cycles; beats on cycles 2..9 after the req edge with no bubble.
- Abort: write burst of 8 at addr 0x20 with req dropped after 2 beats -> only RAM[0x20..0x21] are changed; ack=0 on the next cycle; a following read at 0x20 is served normally.
- Reset asserted asynchronously mid-LAT -> ack=0, wait=0, bus_out=0 immediately without waiting for a clock edge. After release, a new request completes correctly and RAM contents written earlier are intact.
